fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between instruction memory fetch and the two decode slots of the dual-issue front end.
- Producer end of the decoder interface: accepts up to two fetched words per cycle with a PC, compacts them in order, and presents the two oldest instructions to decode slots 0 and 1.
- Decode consumes 0, 1 or 2 per cycle.
- A flush (branch redirect or trap) empties the queue in one cycle.

Parameters:
- DEPTH, 8, queue capacity in instructions; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all queued instructions.
- fetch_valid_i  in  2  per-word valid; bit0 is the word at fetch_pc_i, bit1 is the word at fetch_pc_i+4.
- fetch_inst_i  in  64  [31:0] word 0, [63:32] word 1.
- fetch_pc_i  in  32  PC of word 0, word aligned.
- fetch_ready_o  out  1  queue can accept a fetch this cycle.
- dec_inst0_o  out  32  oldest instruction.
- dec_pc0_o  out  32  PC of dec_inst0_o.
- dec_valid0_o  out  1  slot 0 holds an instruction.
- dec_inst1_o  out  32  second-oldest instruction.
- dec_pc1_o  out  32  PC of dec_inst1_o.
- dec_valid1_o  out  1  slot 1 holds an instruction.
- dec_take_i  in  2  number of instructions decode consumes this cycle: 0, 1 or 2.
- count_o  out  PTR_W+1  current occupancy.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each {inst[31:0], pc[31:0]}.
  - Head and tail pointers are PTR_W bits and wrap modulo DEPTH.
  - Occupancy counter is PTR_W+1 bits.
- Reset (rstn_i low, asynchronous):
  - Head, tail and count clear to 0.
  - Outputs: fetch_ready_o=1, dec_valid0_o=0, dec_valid1_o=0, count_o=0.
  - dec_inst0_o and dec_inst1_o = 32'h00000013 (NOP); dec_pc0_o and dec_pc1_o = 0.
  - Entry contents are not reset.
- fetch_ready_o = (DEPTH - count) >= 2. It is computed from registered count only and does not depend on dec_take_i.
- Push occurs when fetch_ready_o is set and fetch_valid_i is nonzero:
  - 2'b11: word 0 then word 1 are written at tail and tail+1; tail += 2. PCs are fetch_pc_i and fetch_pc_i+4.
  - 2'b01: word 0 only; tail += 1.
  - 2'b10: word 1 only, with PC fetch_pc_i+4, written at tail; tail += 1. This covers a redirect to an odd word.
  - When fetch_ready_o is 0, the fetch is ignored; the fetch unit holds it.
- Output slots are combinational reads:
  - Slot 0 shows entry[head]; dec_valid0_o = (count >= 1).
  - Slot 1 shows entry[head+1]; dec_valid1_o = (count >= 2).
  - An invalid slot drives inst = NOP (32'h00000013) and pc = 0.
- Pop: head += dec_take_i.
  - dec_take_i must not exceed the number of valid slots. Any excess is clamped to the valid count and is not an error.
  - dec_take_i = 3 is treated as 2.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Write and read never collide because the push uses only free slots.
- Latency: a pushed word is visible on the dec_* outputs the next cycle, at the earliest.
- Flush:
  - flush_i high at an edge sets head = tail = count = 0.
  - Flush overrides any push and pop in the same cycle; the concurrent fetch is dropped.
  - The next cycle shows empty outputs and fetch_ready_o=1.
- Order is strictly FIFO; slot 0 is always older than slot 1.

Optional Feature:
- Macro FETCHQ_BYPASS_EN.
- When defined, if count = 0, no flush is asserted, and the fetch is valid, the fetched words drive the dec_* slots combinationally in the same cycle:
  - Compacted as for a push; a 2'b10 fetch drives slot 0.
  - dec_take_i then consumes from the bypassed words.
  - Only the unconsumed remainder is written at tail.
  - Zero-cycle latency after an empty queue or a redirect.
- When undefined, the behaviour is exactly as above, with a minimum latency of one cycle.

Test Plan:
- Reset then idle -> dec_valid0_o=0, dec_valid1_o=0, dec_inst0_o=32'h00000013, fetch_ready_o=1, count_o=0.
- Fetch valid=11, pc=32'h100, inst={32'hB,32'hA}, dec_take_i=0 -> next cycle slot0=A/32'h100, slot1=B/32'h104, count_o=2.
- Fetch valid=10 at pc=32'h200 -> slot0=word1, pc0=32'h204, dec_valid1_o=0.
- Fill to DEPTH=8 with dec_take_i=0 -> fetch_ready_o=0 at count 7 and 8. A further fetch is ignored; count stays 8. Pop 2 -> fetch_ready_o=1.
- Steady push of 2 and take of 2 for 20 cycles across pointer wrap -> output order matches push order and count is constant.
- With 5 queued, assert flush_i with a fetch and take=2 in the same cycle -> next cycle count_o=0, both slots invalid, the fetch is dropped; with FETCHQ_BYPASS_EN, a fetch in the following cycle appears on slot 0 in that same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction buffer between the fetch unit and the two decode slots of the
//   dual-issue front end. Accepts up to two fetched words per cycle, compacts
//   them in program order into a circular store, and presents the two oldest
//   instructions to decode. Decode consumes 0, 1 or 2 per cycle; a flush
//   empties the queue in one cycle.
//
//   Optional build macro: FETCHQ_BYPASS_EN
//     When defined, a fetch arriving while the queue is empty (and no flush is
//     asserted) drives the decode slots combinationally in the same cycle. Only
//     the words decode does not consume that cycle are written into the queue.
//
// Ports
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   flush_i        discard all queued instructions (overrides push and pop)
//   fetch_valid_i  per-word valid: bit0 = word at fetch_pc_i, bit1 = word at +4
//   fetch_inst_i   [31:0] word 0, [63:32] word 1
//   fetch_pc_i     PC of word 0 (word aligned)
//   fetch_ready_o  at least two free entries; fetch is accepted this cycle
//   dec_inst0_o / dec_pc0_o / dec_valid0_o   oldest instruction
//   dec_inst1_o / dec_pc1_o / dec_valid1_o   second-oldest instruction
//   dec_take_i     instructions consumed by decode this cycle (3 acts as 2)
//   count_o        registered occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic [1:0]       fetch_valid_i,
  input  logic [63:0]      fetch_inst_i,
  input  logic [31:0]      fetch_pc_i,
  output logic             fetch_ready_o,
  output logic [31:0]      dec_inst0_o,
  output logic [31:0]      dec_pc0_o,
  output logic             dec_valid0_o,
  output logic [31:0]      dec_inst1_o,
  output logic [31:0]      dec_pc1_o,
  output logic             dec_valid1_o,
  input  logic [1:0]       dec_take_i,
  output logic [PTR_W:0]   count_o
);

  localparam logic [31:0]    NOP          = 32'h0000_0013;
  localparam logic [PTR_W:0] CNT_ZERO     = '0;
  localparam logic [PTR_W:0] CNT_ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO      = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_PUSH_MAX = (PTR_W+1)'(DEPTH - 2);

  // Decode may ask for more than is valid; clamp instead of underflowing.
  function automatic logic [1:0] clamp_take(input logic [1:0] take,
                                            input logic [1:0] avail);
    logic [1:0] t;
    t = (take == 2'd3) ? 2'd2 : take;
    return (t > avail) ? avail : t;
  endfunction

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [31:0]      pc_plus4;
  logic [31:0]      comp0_inst, comp0_pc;
  logic [1:0]       push_n, pop_n, q_pop_n, wr_n, avail_n;
  logic [31:0]      wr0_inst, wr0_pc;
  logic             bypass;

  always_comb begin
    head_p1       = head_q + 1'b1;
    tail_p1       = tail_q + 1'b1;
    pc_plus4      = fetch_pc_i + 32'd4;
    fetch_ready_o = (count_q <= CNT_PUSH_MAX);

    // A lone word-1 fetch (redirect to an odd word) compacts into position 0.
    comp0_inst = (fetch_valid_i == 2'b10) ? fetch_inst_i[63:32] : fetch_inst_i[31:0];
    comp0_pc   = (fetch_valid_i == 2'b10) ? pc_plus4 : fetch_pc_i;

    push_n = 2'd0;
    if (fetch_ready_o && !flush_i) begin
      if (fetch_valid_i == 2'b11)      push_n = 2'd2;
      else if (fetch_valid_i != 2'b00) push_n = 2'd1;
    end

    bypass = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass = (count_q == CNT_ZERO) && !flush_i && (fetch_valid_i != 2'b00);
`endif

    dec_valid0_o = 1'b0;
    dec_inst0_o  = NOP;
    dec_pc0_o    = '0;
    dec_valid1_o = 1'b0;
    dec_inst1_o  = NOP;
    dec_pc1_o    = '0;

    if (bypass) begin
      dec_valid0_o = 1'b1;
      dec_inst0_o  = comp0_inst;
      dec_pc0_o    = comp0_pc;
      if (fetch_valid_i == 2'b11) begin
        dec_valid1_o = 1'b1;
        dec_inst1_o  = fetch_inst_i[63:32];
        dec_pc1_o    = pc_plus4;
      end
      avail_n = push_n;
    end else begin
      if (count_q >= CNT_ONE) begin
        dec_valid0_o = 1'b1;
        dec_inst0_o  = inst_mem[head_q];
        dec_pc0_o    = pc_mem[head_q];
      end
      if (count_q >= CNT_TWO) begin
        dec_valid1_o = 1'b1;
        dec_inst1_o  = inst_mem[head_p1];
        dec_pc1_o    = pc_mem[head_p1];
      end
      avail_n = (count_q >= CNT_TWO) ? 2'd2 : count_q[1:0];
    end

    pop_n = clamp_take(dec_take_i, avail_n);

    // In bypass the consumed words come from the fetch, never from storage;
    // only the unconsumed tail of the fetch is written.
    if (bypass) begin
      wr_n     = push_n - pop_n;
      q_pop_n  = 2'd0;
      wr0_inst = (pop_n == 2'd0) ? comp0_inst : fetch_inst_i[63:32];
      wr0_pc   = (pop_n == 2'd0) ? comp0_pc   : pc_plus4;
    end else begin
      wr_n     = push_n;
      q_pop_n  = pop_n;
      wr0_inst = comp0_inst;
      wr0_pc   = comp0_pc;
    end

    head_d  = head_q + PTR_W'(q_pop_n);
    tail_d  = tail_q + PTR_W'(wr_n);
    count_d = count_q + (PTR_W+1)'(wr_n) - (PTR_W+1)'(q_pop_n);

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; wr_n is already zero on flush or when not ready.
  always_ff @(posedge clk_i) begin
    if (wr_n != 2'd0) begin
      inst_mem[tail_q] <= wr0_inst;
      pc_mem[tail_q]   <= wr0_pc;
    end
    if (wr_n == 2'd2) begin
      inst_mem[tail_p1] <= fetch_inst_i[63:32];
      pc_mem[tail_p1]   <= pc_plus4;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed self-checking bench for fetch_queue (DEPTH = 8). Inputs change
//   1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic [1:0]  fetch_valid_i;
  logic [63:0] fetch_inst_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic [31:0] dec_inst0_o, dec_pc0_o, dec_inst1_o, dec_pc1_o;
  logic        dec_valid0_o, dec_valid1_o;
  logic [1:0]  dec_take_i;
  logic [3:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(8)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_inst_i  (fetch_inst_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_inst0_o   (dec_inst0_o),
    .dec_pc0_o     (dec_pc0_o),
    .dec_valid0_o  (dec_valid0_o),
    .dec_inst1_o   (dec_inst1_o),
    .dec_pc1_o     (dec_pc1_o),
    .dec_valid1_o  (dec_valid1_o),
    .dec_take_i    (dec_take_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [1:0] v, input logic [31:0] w1,
                       input logic [31:0] w0, input logic [31:0] pc);
    fetch_valid_i = v;
    fetch_inst_i  = {w1, w0};
    fetch_pc_i    = pc;
  endtask

  task automatic idle();
    fetch_valid_i = 2'b00;
    dec_take_i    = 2'd0;
    flush_i       = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    idle();
    fetch_inst_i = '0;
    fetch_pc_i   = '0;
    #1;
    // Reset state, checked while reset is held.
    chk("rst_count", count_o, 4'd0);
    chk("rst_ready", fetch_ready_o, 1'b1);
    chk("rst_v0", dec_valid0_o, 1'b0);
    chk("rst_v1", dec_valid1_o, 1'b0);
    chk("rst_inst0", dec_inst0_o, NOP);
    chk("rst_inst1", dec_inst1_o, NOP);
    chk("rst_pc0", dec_pc0_o, 32'h0);
    cyc(); cyc();
    rstn_i = 1'b1;
    cyc();
    chk("idle_count", count_o, 4'd0);
    chk("idle_v0", dec_valid0_o, 1'b0);

    // Dual-word fetch into empty queue.
    fetch(2'b11, 32'hB, 32'hA, 32'h100);
`ifndef FETCHQ_BYPASS_EN
    #1 chk("no_bypass_v0", dec_valid0_o, 1'b0);
`endif
    cyc();
    idle();
    #1;
    chk("p11_inst0", dec_inst0_o, 32'hA);
    chk("p11_pc0", dec_pc0_o, 32'h100);
    chk("p11_inst1", dec_inst1_o, 32'hB);
    chk("p11_pc1", dec_pc1_o, 32'h104);
    chk("p11_v1", dec_valid1_o, 1'b1);
    chk("p11_count", count_o, 4'd2);
    dec_take_i = 2'd2;
    cyc();
    idle();
    chk("take2_count", count_o, 4'd0);
    chk("take2_v0", dec_valid0_o, 1'b0);

    // Odd-word redirect: only word 1 valid.
    fetch(2'b10, 32'hD, 32'hC, 32'h200);
    cyc();
    idle();
    #1;
    chk("p10_inst0", dec_inst0_o, 32'hD);
    chk("p10_pc0", dec_pc0_o, 32'h204);
    chk("p10_v0", dec_valid0_o, 1'b1);
    chk("p10_v1", dec_valid1_o, 1'b0);
    chk("p10_count", count_o, 4'd1);
    dec_take_i = 2'd2;          // excess take clamps to 1
    cyc();
    idle();
    chk("clamp_count", count_o, 4'd0);

    // Fill toward full.
    fetch(2'b11, 32'h1001, 32'h1000, 32'h300); cyc();
    fetch(2'b11, 32'h1003, 32'h1002, 32'h308); cyc();
    fetch(2'b11, 32'h1005, 32'h1004, 32'h310); cyc();
    idle();
    chk("fill6_count", count_o, 4'd6);
    chk("fill6_ready", fetch_ready_o, 1'b1);
    fetch(2'b01, 32'hDEAD, 32'h1006, 32'h318); cyc();
    idle();
    chk("fill7_count", count_o, 4'd7);
    chk("fill7_ready", fetch_ready_o, 1'b0);
    fetch(2'b11, 32'hBAD1, 32'hBAD0, 32'h900); cyc();
    idle();
    chk("ign7_count", count_o, 4'd7);
    dec_take_i = 2'd1; cyc(); idle();
    chk("pop1_count", count_o, 4'd6);
    chk("pop1_inst0", dec_inst0_o, 32'h1001);
    fetch(2'b11, 32'h1008, 32'h1007, 32'h31C); cyc();
    idle();
    chk("full_count", count_o, 4'd8);
    chk("full_ready", fetch_ready_o, 1'b0);
    fetch(2'b11, 32'hBAD3, 32'hBAD2, 32'h900); cyc();
    idle();
    chk("ign8_count", count_o, 4'd8);
    dec_take_i = 2'd2; cyc(); idle();
    chk("pop2_ready", fetch_ready_o, 1'b1);
    chk("pop2_count", count_o, 4'd6);
    chk("pop2_inst0", dec_inst0_o, 32'h1003);
    dec_take_i = 2'd2; cyc(); idle();
    chk("drain_inst0", dec_inst0_o, 32'h1005);
    chk("drain_inst1", dec_inst1_o, 32'h1006);
    dec_take_i = 2'd2; cyc(); idle();
    chk("drain_inst0b", dec_inst0_o, 32'h1007);
    chk("drain_pc1b", dec_pc1_o, 32'h320);
    dec_take_i = 2'd3; cyc(); idle();   // 3 behaves as 2
    chk("take3_count", count_o, 4'd0);

    // Steady push 2 / take 2 across pointer wrap.
    fetch(2'b11, 32'h2001, 32'h2000, 32'h4000); cyc();
    for (int i = 1; i <= 20; i++) begin
      fetch(2'b11, 32'h2000 + 32'(2*i) + 32'd1, 32'h2000 + 32'(2*i), 32'h4000 + 32'(8*i));
      dec_take_i = 2'd2;
      cyc();
      chk("stdy_inst0", dec_inst0_o, 32'h2000 + 32'(2*i));
      chk("stdy_inst1", dec_inst1_o, 32'h2000 + 32'(2*i) + 32'd1);
      chk("stdy_pc1", dec_pc1_o, 32'h4004 + 32'(8*i));
      chk("stdy_count", count_o, 4'd2);
    end
    idle();
    dec_take_i = 2'd2; cyc(); idle();
    chk("stdy_end", count_o, 4'd0);

    // Flush with concurrent fetch and take.
    fetch(2'b11, 32'h3001, 32'h3000, 32'h500); cyc();
    fetch(2'b11, 32'h3003, 32'h3002, 32'h508); cyc();
    fetch(2'b01, 32'h0,    32'h3004, 32'h510); cyc();
    idle();
    chk("pre_flush_count", count_o, 4'd5);
    flush_i = 1'b1;
    dec_take_i = 2'd2;
    fetch(2'b11, 32'h3F01, 32'h3F00, 32'h700);
    cyc();
    idle();
    chk("fl_count", count_o, 4'd0);
    chk("fl_v0", dec_valid0_o, 1'b0);
    chk("fl_v1", dec_valid1_o, 1'b0);
    chk("fl_inst0", dec_inst0_o, NOP);
    chk("fl_ready", fetch_ready_o, 1'b1);
    fetch(2'b11, 32'hC1, 32'hC0, 32'h600);
    #1;
`ifdef FETCHQ_BYPASS_EN
    chk("byp_v0", dec_valid0_o, 1'b1);
    chk("byp_inst0", dec_inst0_o, 32'hC0);
    chk("byp_pc0", dec_pc0_o, 32'h600);
`else
    chk("nobyp_v0", dec_valid0_o, 1'b0);
`endif
    cyc();
    idle();
    chk("postfl_count", count_o, 4'd2);
    chk("postfl_inst0", dec_inst0_o, 32'hC0);
    chk("postfl_pc1", dec_pc1_o, 32'h604);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
